req_shaper: RTL and testbench

REQ_SHAPER -- requirements
Module: req_shaper

---
 rtl/req_shaper.sv | 126 ++++++++++++
 tb/tb_req_shaper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/req_shaper.sv
// Two-client request shaper: per-client pending counters, overflow and late-ack tracking.
// Optional per-client starvation watchdog enabled by defining REQ_SHAPER_WATCHDOG_EN.
module req_shaper #(
   parameter int unsigned DEPTH    = 7,
   parameter int unsigned WD_LIMIT = 15
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push0,
   input  logic       push1,
   input  logic       ack0,
   input  logic       ack1,
   input  logic       clear,
   output logic       ir0,
   output logic       ir1,
   output logic       full0,
   output logic       full1,
   output logic       ovf0,
   output logic       ovf1,
   output logic [3:0] late_cnt,
   output logic       starve0,
   output logic       starve1
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned NC = 2;

   if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
      $error("req_shaper: DEPTH must be in 1..15");
   end
   if (WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_bad_wd_limit
      $error("req_shaper: WD_LIMIT must be in 1..255");
   end

   logic [NC-1:0] push;
   logic [NC-1:0] ack;
   logic [NC-1:0] ir;
   logic [CW-1:0] pend_q [NC];
   logic [CW-1:0] pend_d [NC];
   logic [NC-1:0] ovf_q, ovf_d;
   logic [NC-1:0] drop, late;
   logic [3:0]    late_cnt_q, late_cnt_d;
   logic [4:0]    late_sum;

   assign push = {push1, push0};
   assign ack  = {ack1, ack0};

   // Pending counter update; a push+ack pair on an empty client counts as a late ack.
   always_comb begin
      drop = '0;
      late = '0;
      for (int i = 0; i < NC; i++) begin
         pend_d[i] = pend_q[i];
         ir[i]     = (pend_q[i] != '0);
         if (pend_q[i] == '0) begin
            late[i] = ack[i];
            if (push[i]) pend_d[i] = CW'(1);
         end else if (push[i] && !ack[i]) begin
            if (pend_q[i] == CW'(DEPTH)) drop[i] = 1'b1;
            else                         pend_d[i] = pend_q[i] + CW'(1);
         end else if (!push[i] && ack[i]) begin
            pend_d[i] = pend_q[i] - CW'(1);
         end
      end
      ovf_d      = (ovf_q & {NC{~clear}}) | drop;
      late_sum   = 5'(clear ? 4'd0 : late_cnt_q) + 5'(late[0]) + 5'(late[1]);
      late_cnt_d = (late_sum > 5'd15) ? 4'd15 : late_sum[3:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NC; i++) pend_q[i] <= '0;
         ovf_q      <= '0;
         late_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NC; i++) pend_q[i] <= pend_d[i];
         ovf_q      <= ovf_d;
         late_cnt_q <= late_cnt_d;
      end
   end

`ifdef REQ_SHAPER_WATCHDOG_EN
   logic [7:0]    wait_q [NC];
   logic [7:0]    wait_d [NC];
   logic [NC-1:0] starve_q, starve_d;

   // Wait counter runs while a request is outstanding and unacknowledged.
   always_comb begin
      starve_d = starve_q & {NC{~clear}};
      for (int i = 0; i < NC; i++) begin
         wait_d[i] = wait_q[i];
         if (ack[i] || !ir[i]) begin
            wait_d[i] = '0;
         end else begin
            if (wait_q[i] != 8'hFF) wait_d[i] = wait_q[i] + 8'd1;
            if (wait_q[i] == 8'(WD_LIMIT - 1)) starve_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NC; i++) wait_q[i] <= '0;
         starve_q <= '0;
      end else begin
         for (int i = 0; i < NC; i++) wait_q[i] <= wait_d[i];
         starve_q <= starve_d;
      end
   end

   assign starve0 = starve_q[0];
   assign starve1 = starve_q[1];
`else
   assign starve0 = 1'b0;
   assign starve1 = 1'b0;
`endif

   assign ir0      = ir[0];
   assign ir1      = ir[1];
   assign full0    = (pend_q[0] == CW'(DEPTH));
   assign full1    = (pend_q[1] == CW'(DEPTH));
   assign ovf0     = ovf_q[0];
   assign ovf1     = ovf_q[1];
   assign late_cnt = late_cnt_q;

endmodule

// File: tb/tb_req_shaper.sv
// Directed bench for req_shaper: a vector table of per-cycle inputs/expected outputs,
// followed by hand-written reset, late-ack and watchdog sequences.
module tb_req_shaper;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       push0, push1, ack0, ack1, clear;
   logic       ir0, ir1, full0, full1, ovf0, ovf1, starve0, starve1;
   logic [3:0] late_cnt;
   logic [9:0] obs;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       p0, a0, p1, a1, clr;
      logic [9:0] exp;   // {ir0, ir1, full0, full1, ovf0, ovf1, late_cnt}
   } vec_t;

   vec_t vecs[$];

   req_shaper #(.DEPTH(7), .WD_LIMIT(4)) dut (
      .clock(clk), .reset_n(rst_n),
      .push0(push0), .push1(push1), .ack0(ack0), .ack1(ack1), .clear(clear),
      .ir0(ir0), .ir1(ir1), .full0(full0), .full1(full1),
      .ovf0(ovf0), .ovf1(ovf1), .late_cnt(late_cnt),
      .starve0(starve0), .starve1(starve1)
   );

   always #5 clk = ~clk;

   assign obs = {ir0, ir1, full0, full1, ovf0, ovf1, late_cnt};

   function automatic vec_t mk(input logic p0, a0, p1, a1, clr,
                               input logic i0, i1, f0, f1, o0, o1,
                               input logic [3:0] lc);
      vec_t v;
      v.p0 = p0; v.a0 = a0; v.p1 = p1; v.a1 = a1; v.clr = clr;
      v.exp = {i0, i1, f0, f1, o0, o1, lc};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample just after the rising edge.
   task automatic step(input logic p0, a0, p1, a1, clr);
      push0 = p0; ack0 = a0; push1 = p1; ack1 = a1; clear = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_st;

      // Table: starts from reset, both counters empty, late_cnt 0
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,0,0,0, 1,0,0,0,0,0,4'd0));
      for (int k = 0; k < 6; k++) vecs.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0,4'd0));
      vecs.push_back(mk(0,0,1,0,0, 1,1,0,1,0,0,4'd0));
      for (int k = 0; k < 2; k++) vecs.push_back(mk(0,0,1,0,0, 1,1,0,1,0,1,4'd0));
      vecs.push_back(mk(0,0,0,0,1, 1,1,0,1,0,0,4'd0));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,0,0,0, 1,1,0,1,0,0,4'd0));
      vecs.push_back(mk(1,0,0,0,0, 1,1,1,1,0,0,4'd0));
      vecs.push_back(mk(1,1,0,0,0, 1,1,1,1,0,0,4'd0));
      vecs.push_back(mk(1,0,0,0,1, 1,1,1,1,1,0,4'd0));
      vecs.push_back(mk(0,1,0,1,0, 1,1,0,0,1,0,4'd0));
      vecs.push_back(mk(0,0,0,0,1, 1,1,0,0,0,0,4'd0));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(0,1,0,1,0, 1,1,0,0,0,0,4'd0));
      vecs.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0,4'd0));
      vecs.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0,4'd2));
      vecs.push_back(mk(1,1,0,1,0, 1,0,0,0,0,0,4'd4));
      vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0,4'd4));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0,4'(6 + 2*k)));
      vecs.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0,4'd15));
      vecs.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0,4'd15));
      vecs.push_back(mk(0,1,0,0,1, 0,0,0,0,0,0,4'd1));
      vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,4'd0));

      push0 = 0; push1 = 0; ack0 = 0; ack1 = 0; clear = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'(obs), 32'd0);
      chk("reset_starve", 32'({starve0, starve1}), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].p0, vecs[i].a0, vecs[i].p1, vecs[i].a1, vecs[i].clr);
         chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
      end

      // pend0=1 then three acks: ir0 drops on the first, two late acks follow
      step(1,0,0,0,0);
      chk("late_seq_ir_up", 32'(ir0), 32'd1);
      step(0,1,0,0,0);
      chk("late_seq_ir_down", 32'(ir0), 32'd0);
      step(0,1,0,0,0);
      step(0,1,0,0,0);
      chk("late_seq_cnt", 32'(late_cnt), 32'd2);

      // Build pend0=5, pend1=2, then assert reset between edges
      step(1,0,1,0,0);
      step(1,0,1,0,0);
      repeat (3) step(1,0,0,0,0);
      step(0,0,0,0,0);
      chk("pre_reset", 32'(obs), 32'({1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'd2}));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 32'(obs), 32'd0);
      push0 = 1'b1;
      @(posedge clk);
      #1;
      chk("push_during_reset", 32'(obs), 32'd0);
      rst_n = 1'b1;
      step(1,0,0,0,0);
      chk("first_edge_after_reset", 32'(obs), 32'({1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0}));
      step(0,1,0,0,0);
      chk("pend0_was_one", 32'(obs), 32'd0);

      // Watchdog: WD_LIMIT=4, starve0 sets on the 4th waiting edge and is sticky
      step(0,0,0,0,1);
      chk("wd_clear", 32'({starve0, starve1}), 32'd0);
      step(1,0,0,0,0);
      chk("wd_push", 32'({starve0, starve1}), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(0,0,0,0,0);
`ifdef REQ_SHAPER_WATCHDOG_EN
         exp_st = (k == 3);
`else
         exp_st = 1'b0;
`endif
         chk($sformatf("wd_wait%0d", k + 1), 32'({starve0, starve1}), 32'({exp_st, 1'b0}));
      end
      step(0,1,0,0,0);
      chk("wd_sticky_after_ack", 32'({starve0, starve1}), 32'({exp_st, 1'b0}));
      chk("wd_ir_after_ack", 32'(ir0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
